// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register, decoder and control FSM for a simple datapath
// Control outputs are registered from the next state and next IR so that they stay Moore.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        illegal,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        write,
    output logic [1:0]  vsel
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG, S_WRITE_IMM
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic        w_q, w_d, illegal_q, illegal_d;
    logic        loada_q, loada_d, loadb_q, loadb_d, loadc_q, loadc_d;
    logic        loads_q, loads_d, asel_q, asel_d, write_q, write_d;
    logic [1:0]  vsel_q, vsel_d;
    logic [2:0]  regnum_q, regnum_d;

    logic [2:0]  cur_opcode, nxt_opcode;
    logic [1:0]  cur_op, nxt_op;
    logic        nxt_mov_reg, nxt_cmp, nxt_legal;

    assign cur_opcode = ir_q[15:13];
    assign cur_op     = ir_q[12:11];
    assign nxt_opcode = ir_d[15:13];
    assign nxt_op     = ir_d[12:11];
    assign nxt_mov_reg = (nxt_opcode == 3'b110) && (nxt_op == 2'b00);
    assign nxt_cmp     = (nxt_opcode == 3'b101) && (nxt_op == 2'b01);
    assign nxt_legal   = (nxt_opcode == 3'b101) ||
                         ((nxt_opcode == 3'b110) && ((nxt_op == 2'b10) || (nxt_op == 2'b00)));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (load) ir_d = in;
                if (s)    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cur_opcode == 3'b110 && cur_op == 2'b10)      state_d = S_WRITE_IMM;
                else if (cur_opcode == 3'b110 && cur_op == 2'b00) state_d = S_GET_B;
                else if (cur_opcode == 3'b101)                    state_d = S_GET_A;
                else                                              state_d = S_WAIT;
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = (cur_opcode == 3'b101 && cur_op == 2'b01) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Next-cycle control values, a pure function of the upcoming state and IR.
    always_comb begin
        w_d       = 1'b0;
        illegal_d = 1'b0;
        loada_d   = 1'b0;
        loadb_d   = 1'b0;
        loadc_d   = 1'b0;
        loads_d   = 1'b0;
        asel_d    = 1'b0;
        write_d   = 1'b0;
        vsel_d    = 2'b00;
        regnum_d  = 3'b000;
        case (state_d)
            S_WAIT:   w_d = 1'b1;
            S_DECODE: illegal_d = !nxt_legal;
            S_GET_A: begin
                loada_d  = 1'b1;
                regnum_d = ir_d[10:8];
            end
            S_GET_B: begin
                loadb_d  = 1'b1;
                regnum_d = ir_d[2:0];
            end
            S_EXEC: begin
                asel_d  = nxt_mov_reg;
                loadc_d = !nxt_cmp;
                loads_d = nxt_cmp;
            end
            S_WRITE_REG: begin
                write_d  = 1'b1;
                regnum_d = ir_d[7:5];
            end
            S_WRITE_IMM: begin
                write_d  = 1'b1;
                vsel_d   = 2'b01;
                regnum_d = ir_d[10:8];
            end
            default: w_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_WAIT;
            ir_q      <= 16'h0000;
            w_q       <= 1'b1;
            illegal_q <= 1'b0;
            loada_q   <= 1'b0;
            loadb_q   <= 1'b0;
            loadc_q   <= 1'b0;
            loads_q   <= 1'b0;
            asel_q    <= 1'b0;
            write_q   <= 1'b0;
            vsel_q    <= 2'b00;
            regnum_q  <= 3'b000;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            w_q       <= w_d;
            illegal_q <= illegal_d;
            loada_q   <= loada_d;
            loadb_q   <= loadb_d;
            loadc_q   <= loadc_d;
            loads_q   <= loads_d;
            asel_q    <= asel_d;
            write_q   <= write_d;
            vsel_q    <= vsel_d;
            regnum_q  <= regnum_d;
        end
    end

    assign w        = w_q;
    assign illegal  = illegal_q;
    assign loada    = loada_q;
    assign loadb    = loadb_q;
    assign loadc    = loadc_q;
    assign loads    = loads_q;
    assign asel     = asel_q;
    assign write    = write_q;
    assign vsel     = vsel_q;
    assign readnum  = regnum_q;
    assign writenum = regnum_q;
    assign ALUop    = ir_q[12:11];
    assign shift    = ir_q[4:3];
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load, s;
    logic        w, illegal, loada, loadb, loadc, loads, asel, write;
    logic [1:0]  ALUop, shift, vsel;
    logic [15:0] sximm8;
    logic [2:0]  readnum, writenum;

    int checks = 0;
    int errors = 0;

    cpu_controller dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
        .w(w), .illegal(illegal), .ALUop(ALUop), .shift(shift), .sximm8(sximm8),
        .readnum(readnum), .writenum(writenum),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .write(write), .vsel(vsel)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cv(input logic ew, input logic eill, input logic ela,
                                       input logic elb, input logic elc, input logic els,
                                       input logic eas, input logic ewr, input logic [1:0] evs,
                                       input logic [2:0] ern, input logic [2:0] ewn);
        return {ew, eill, ela, elb, elc, els, eas, ewr, evs, ern, ewn};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [15:0] exp);
        chk(tag, {w, illegal, loada, loadb, loadc, loads, asel, write, vsel, readnum, writenum}, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] instr);
        in = instr; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0; in = 16'hFFFF;
    endtask

    localparam logic [15:0] IDLE = 16'h8000;

    initial begin
        reset = 1'b1; in = 16'h0000; load = 1'b0; s = 1'b0;
        #1;
        chk_ctrl("reset_ctrl", IDLE);
        chk("reset_sximm8", sximm8, 16'h0000);
        chk("reset_aluop_shift", {12'h0, ALUop, shift}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // MOV imm, w low for exactly two sampled cycles
        issue(16'hD007);
        chk_ctrl("movi_decode", cv(0,0,0,0,0,0,0,0,2'b00,3'd0,3'd0));
        step();
        chk_ctrl("movi_write_imm", cv(0,0,0,0,0,0,0,1,2'b01,3'd0,3'd0));
        chk("movi_sximm8", sximm8, 16'h0007);
        step();
        chk_ctrl("movi_wait", IDLE);

        issue(16'hD1F9);
        step();
        chk_ctrl("movi_neg_write_imm", cv(0,0,0,0,0,0,0,1,2'b01,3'd1,3'd1));
        chk("movi_neg_sximm8", sximm8, 16'hFFF9);
        step();
        chk_ctrl("movi_neg_wait", IDLE);

        // ADD R2 = R1 + R0
        issue(16'hA140);
        chk_ctrl("add_decode", cv(0,0,0,0,0,0,0,0,2'b00,3'd0,3'd0));
        step();
        chk_ctrl("add_get_a", cv(0,0,1,0,0,0,0,0,2'b00,3'd1,3'd1));
        step();
        chk_ctrl("add_get_b", cv(0,0,0,1,0,0,0,0,2'b00,3'd0,3'd0));
        step();
        chk_ctrl("add_exec", cv(0,0,0,0,1,0,0,0,2'b00,3'd0,3'd0));
        chk("add_aluop", {14'h0, ALUop}, 16'h0000);
        step();
        chk_ctrl("add_write_reg", cv(0,0,0,0,0,0,0,1,2'b00,3'd2,3'd2));
        step();
        chk_ctrl("add_wait", IDLE);

        // CMP: status load only, no write-back
        issue(16'hA900);
        step();
        chk_ctrl("cmp_get_a", cv(0,0,1,0,0,0,0,0,2'b00,3'd1,3'd1));
        step();
        chk_ctrl("cmp_get_b", cv(0,0,0,1,0,0,0,0,2'b00,3'd0,3'd0));
        step();
        chk_ctrl("cmp_exec", cv(0,0,0,0,0,1,0,0,2'b00,3'd0,3'd0));
        chk("cmp_aluop", {14'h0, ALUop}, 16'h0001);
        step();
        chk_ctrl("cmp_wait", IDLE);

        // MVN with load and s requests during EXEC that must be ignored
        issue(16'hB868);
        chk("mvn_shift", {14'h0, shift}, 16'h0001);
        chk("mvn_aluop", {14'h0, ALUop}, 16'h0003);
        step();
        step();
        step();
        chk_ctrl("mvn_exec", cv(0,0,0,0,1,0,0,0,2'b00,3'd0,3'd0));
        in = 16'hD1F9; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0;
        chk_ctrl("mvn_write_reg", cv(0,0,0,0,0,0,0,1,2'b00,3'd3,3'd3));
        chk("mvn_ir_kept_aluop", {14'h0, ALUop}, 16'h0003);
        chk("mvn_ir_kept_sximm8", sximm8, 16'h0068);
        step();
        chk_ctrl("mvn_wait", IDLE);

        // Undefined opcode
        issue(16'h0000);
        chk_ctrl("ill_decode", cv(0,1,0,0,0,0,0,0,2'b00,3'd0,3'd0));
        step();
        chk_ctrl("ill_wait", IDLE);

        // MOV reg R2 = R3
        issue(16'hC043);
        step();
        chk_ctrl("movr_get_b", cv(0,0,0,1,0,0,0,0,2'b00,3'd3,3'd3));
        step();
        chk_ctrl("movr_exec", cv(0,0,0,0,1,0,1,0,2'b00,3'd0,3'd0));
        step();
        chk_ctrl("movr_write_reg", cv(0,0,0,0,0,0,0,1,2'b00,3'd2,3'd2));
        step();
        chk_ctrl("movr_wait", IDLE);

        // Asynchronous abort in GET_B
        issue(16'hA140);
        step();
        step();
        chk_ctrl("abort_get_b", cv(0,0,0,1,0,0,0,0,2'b00,3'd0,3'd0));
        #2 reset = 1'b1;
        #1;
        chk_ctrl("abort_async", IDLE);
        chk("abort_sximm8", sximm8, 16'h0000);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_ctrl("abort_after1", IDLE);
        step();
        chk_ctrl("abort_after2", IDLE);

        // First s after reset is honoured
        issue(16'hD007);
        chk_ctrl("post_reset_decode", cv(0,0,0,0,0,0,0,0,2'b00,3'd0,3'd0));
        step();
        chk_ctrl("post_reset_write_imm", cv(0,0,0,0,0,0,0,1,2'b01,3'd0,3'd0));
        step();
        chk_ctrl("post_reset_wait", IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
